// File: rtl/tick_sched_pkg.sv
// Shared types for the tick_sched timer scheduler: command opcodes and the
// per-channel state encoding.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        OP_NOP            = 2'd0,
        OP_START_ONESHOT  = 2'd1,
        OP_START_PERIODIC = 2'd2,
        OP_STOP           = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ONESHOT  = 2'd1,
        ST_PERIODIC = 2'd2
    } ch_state_e;

endpackage

// File: rtl/tick_sched_if.sv
// Command port of tick_sched: valid/ready handshake carrying channel, opcode
// and period. The master drives the request, the scheduler is the slave.
interface tick_sched_if #(
    parameter int CH_NUM   = 4,
    parameter int PERIOD_W = 16
);
    import tick_sched_pkg::*;

    localparam int CH_W = $clog2(CH_NUM);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [CH_W-1:0]     cmd_ch;
    op_e                 cmd_op;
    logic [PERIOD_W-1:0] cmd_period;

    modport master (
        output cmd_valid, cmd_ch, cmd_op, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_op, cmd_period,
        output cmd_ready
    );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV_COUNT-1 and emits a registered one-clock tick
// whenever the count is zero, i.e. once every DIV_COUNT clocks.
module tick_gen #(
    parameter int DIV_COUNT = 10000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(DIV_COUNT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples the pre-edge value of every other register.
            tick <= (count == '0);
            if (count == CW'(DIV_COUNT - 1))
                count <= '0;
            else
                count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel timer scheduler sharing one prescaler tick among CH_NUM
// down-counting channels. Define TICK_SCHED_IRQ_EN to add irq_mask/irq.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int DIV_COUNT = 10000,
    parameter int CH_NUM    = 4,
    parameter int PERIOD_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    tick_sched_if.slave       cmd,
    input  logic [CH_NUM-1:0] pend_clr,
`ifdef TICK_SCHED_IRQ_EN
    input  logic [CH_NUM-1:0] irq_mask,
    output logic              irq,
`endif
    output logic              tick,
    output logic [CH_NUM-1:0] evt,
    output logic [CH_NUM-1:0] busy,
    output logic [CH_NUM-1:0] pend
);
    localparam int CH_W = $clog2(CH_NUM);

    logic              accept;
    logic [CH_NUM-1:0] evt_next;

    tick_gen #(.DIV_COUNT(DIV_COUNT)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Commands are refused on tick cycles, so a channel never sees both at once.
    assign cmd.cmd_ready = !tick;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        ch_state_e           state_q, state_d;
        logic [PERIOD_W-1:0] cnt_q, cnt_d;
        logic [PERIOD_W-1:0] reload_q, reload_d;
        logic                hit;
        logic                expire;

        assign hit = accept && (cmd.cmd_ch == CH_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                reload_q <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                reload_q <= reload_d;
            end
        end

        always_comb begin
            // NOTE: every combinational output gets a default first, so no path
            // through the block can leave a value unassigned and infer a latch.
            state_d  = state_q;
            cnt_d    = cnt_q;
            reload_d = reload_q;
            expire   = 1'b0;
            if (hit) begin
                case (cmd.cmd_op)
                    OP_START_ONESHOT, OP_START_PERIODIC: begin
                        if (cmd.cmd_period != '0) begin
                            cnt_d    = cmd.cmd_period;
                            reload_d = cmd.cmd_period;
                            state_d  = (cmd.cmd_op == OP_START_ONESHOT) ? ST_ONESHOT
                                                                         : ST_PERIODIC;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    OP_STOP: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
            end else if (tick && state_q != ST_IDLE) begin
                if (cnt_q > PERIOD_W'(1)) begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end else begin
                    expire = 1'b1;
                    if (state_q == ST_PERIODIC) begin
                        cnt_d = reload_q;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
        end

        assign busy[g]     = (state_q != ST_IDLE);
        assign evt_next[g] = expire;
    end

    // Set wins over clear when an event and a clear strobe coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt  <= '0;
            pend <= '0;
        end else begin
            evt  <= evt_next;
            pend <= (pend & ~pend_clr) | evt;
        end
    end

`ifdef TICK_SCHED_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= |(pend & irq_mask);
    end
`endif

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with DIV_COUNT=4, CH_NUM=4. Cycle numbers in
// comments count clock edges since reset release (ticks on cycles 1,5,9,...).
module tb_tick_sched;
    import tick_sched_pkg::*;

    localparam int DIV_COUNT = 4;
    localparam int CH_NUM    = 4;
    localparam int PERIOD_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH_NUM-1:0] pend_clr;
    logic              tick;
    logic [CH_NUM-1:0] evt;
    logic [CH_NUM-1:0] busy;
    logic [CH_NUM-1:0] pend;
`ifdef TICK_SCHED_IRQ_EN
    logic [CH_NUM-1:0] irq_mask;
    logic              irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tick_sched_if #(.CH_NUM(CH_NUM), .PERIOD_W(PERIOD_W)) cmd_if ();

    tick_sched #(
        .DIV_COUNT (DIV_COUNT),
        .CH_NUM    (CH_NUM),
        .PERIOD_W  (PERIOD_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if.slave),
        .pend_clr (pend_clr),
`ifdef TICK_SCHED_IRQ_EN
        .irq_mask (irq_mask),
        .irq      (irq),
`endif
        .tick     (tick),
        .evt      (evt),
        .busy     (busy),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ch, input op_e op, input int period);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_ch     = 2'(ch);
        cmd_if.cmd_op     = op;
        cmd_if.cmd_period = 16'(period);
    endtask

    initial begin
        rst               = 1'b1;
        pend_clr          = '0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_ch     = '0;
        cmd_if.cmd_op     = OP_NOP;
        cmd_if.cmd_period = '0;
`ifdef TICK_SCHED_IRQ_EN
        irq_mask = 4'b0010;
`endif

        // Reset held for 3 cycles
        cyc(3);
        check("rst_tick",  32'(tick), 32'd0);
        check("rst_evt",   32'(evt),  32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_pend",  32'(pend), 32'd0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
`ifdef TICK_SCHED_IRQ_EN
        check("rst_irq",   32'(irq), 32'd0);
`endif
        rst = 1'b0;

        cyc(1); // 1
        check("tick_first", 32'(tick), 32'd1);
        check("ready_on_tick", 32'(cmd_if.cmd_ready), 32'd0);
        cyc(1); // 2
        check("tick_low", 32'(tick), 32'd0);
        cyc(3); // 5
        check("tick_second", 32'(tick), 32'd1);

        // One-shot, channel 0, period 3: ticks 9,13,17 -> evt on 18
        cyc(1); // 6
        send(0, OP_START_ONESHOT, 3);
        cyc(1); // 7
        cmd_if.cmd_valid = 1'b0;
        check("os_busy", 32'(busy), 32'b0001);
        cyc(10); // 17
        check("os_evt_early", 32'(evt), 32'd0);
        check("os_busy_17", 32'(busy), 32'b0001);
        cyc(1); // 18
        check("os_evt", 32'(evt), 32'b0001);
        check("os_busy_fall", 32'(busy), 32'd0);
        cyc(1); // 19
        check("os_evt_once", 32'(evt), 32'd0);
        check("os_pend", 32'(pend), 32'b0001);
        cyc(3); // 22
        check("os_pend_sticky", 32'(pend), 32'b0001);
        pend_clr = 4'b0001;
        cyc(1); // 23
        pend_clr = '0;
        check("os_pend_clr", 32'(pend), 32'd0);

        // Periodic, channel 1, period 2: evt on 30, 38, ...
        send(1, OP_START_PERIODIC, 2);
        cyc(1); // 24
        cmd_if.cmd_valid = 1'b0;
        check("per_busy", 32'(busy), 32'b0010);
        cyc(5); // 29
        check("per_evt_early", 32'(evt), 32'd0);
        cyc(1); // 30
        check("per_evt1", 32'(evt), 32'b0010);
        cyc(1); // 31
        check("per_evt1_end", 32'(evt), 32'd0);
        check("per_pend", 32'(pend), 32'b0010);
        cyc(6); // 37
        check("per_evt_gap", 32'(evt), 32'd0);
        cyc(1); // 38
        check("per_evt2", 32'(evt), 32'b0010);
        check("per_busy_run", 32'(busy), 32'b0010);
        cyc(1); // 39
        send(1, OP_STOP, 0);
        cyc(1); // 40
        cmd_if.cmd_valid = 1'b0;
        check("per_stop_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) begin // 41..52
            cyc(1);
            check("per_stop_noevt", 32'(evt), 32'd0);
        end

        // Command held across tick cycle 53, accepted at end of cycle 54
        cyc(1); // 53
        send(2, OP_START_PERIODIC, 5);
        check("hs_tick", 32'(tick), 32'd1);
        check("hs_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
        cyc(1); // 54
        check("hs_not_taken", 32'(busy), 32'd0);
        check("hs_ready_high", 32'(cmd_if.cmd_ready), 32'd1);
        cyc(1); // 55
        check("hs_taken", 32'(busy), 32'b0100);
        send(2, OP_START_PERIODIC, 0);
        cyc(1); // 56
        check("p0_stops", 32'(busy), 32'd0);
        send(3, OP_START_ONESHOT, 0);
        cyc(1); // 57
        cmd_if.cmd_valid = 1'b0;
        check("p0_idle", 32'(busy), 32'd0);

        // Channels 2 and 3 with period 1 in the same gap, tick 61 -> evt on 62
        cyc(1); // 58
        send(2, OP_START_ONESHOT, 1);
        cyc(1); // 59
        send(3, OP_START_PERIODIC, 1);
        cyc(1); // 60
        cmd_if.cmd_valid = 1'b0;
        check("sim_busy", 32'(busy), 32'b1100);
        cyc(2); // 62
        check("sim_evt", 32'(evt), 32'b1100);
        check("sim_busy_after", 32'(busy), 32'b1000);
        pend_clr = 4'b0100;
        cyc(1); // 63
        check("race_set_wins", 32'(pend), 32'b1110);
        pend_clr = 4'b1111;
        cyc(1); // 64
        pend_clr = '0;
        check("pend_clr_all", 32'(pend), 32'd0);
        send(3, OP_STOP, 0);
        cyc(1); // 65
        cmd_if.cmd_valid = 1'b0;
        check("sim_stop", 32'(busy), 32'd0);
        cyc(1); // 66
        check("sim_stop_noevt", 32'(evt), 32'd0);

        // Reset mid-operation drops the evt due on cycle 70
        send(3, OP_START_PERIODIC, 1);
        cyc(1); // 67
        cmd_if.cmd_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'b1000);
        cyc(2); // 69
        rst = 1'b1;
        cyc(1); // 70
        check("mid_rst_evt",   32'(evt),  32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_tick",  32'(tick), 32'd0);
        check("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        rst = 1'b0;
        cyc(1); // new cycle 1
        check("mid_rst_tick1", 32'(tick), 32'd1);

`ifdef TICK_SCHED_IRQ_EN
        cyc(1); // 2
        send(0, OP_START_ONESHOT, 1);
        cyc(1); // 3
        cmd_if.cmd_valid = 1'b0;
        cyc(3); // 6
        check("irq_evt0", 32'(evt), 32'b0001);
        cyc(2); // 8
        check("irq_pend0", 32'(pend), 32'b0001);
        check("irq_masked", 32'(irq), 32'd0);
        send(1, OP_START_ONESHOT, 1);
        cyc(1); // 9
        cmd_if.cmd_valid = 1'b0;
        cyc(2); // 11
        check("irq_pend1", 32'(pend), 32'b0011);
        check("irq_not_yet", 32'(irq), 32'd0);
        cyc(1); // 12
        check("irq_raised", 32'(irq), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
